// File: rtl/i2c_register_file_pkg.sv
// Shared types for the I2C register file: FSM state encoding and address-byte layout.
// No logic here; imported by the register file top and its storage bank.
// Nothing in this package adds latency or flow control.
package i2c_register_file_pkg;

  // Transfer-tracking states of the pointer protocol
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PTR   = 2'd1,
    ST_WRITE = 2'd2,
    ST_READ  = 2'd3
  } state_t;

  // Bit of the received address byte that carries R/W# (1 = read)
  localparam int RW_BIT = 0;

endpackage

// File: rtl/i2c_register_file_reg_bank.sv
// Register storage: RW bytes with indexed write, plus a read mux over RW bytes and ro_in.
// Latency: writes land on the clock edge after wr_en; rd_data is combinational from rd_addr.
// Backpressure: none; every write request is accepted in the cycle it is presented.
module i2c_register_file_reg_bank
  import i2c_register_file_pkg::*;
#(
  parameter int PTR_W    = 4,
  parameter int RW_COUNT = 8,
  parameter int RO_W     = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [PTR_W-1:0]      wr_addr,
  input  logic [7:0]            wr_data,
  input  logic [PTR_W-1:0]      rd_addr,
  input  logic [RO_W-1:0]       ro_in,
  output logic [8*RW_COUNT-1:0] regs_out,
  output logic [7:0]            rd_data
);

  localparam int NREG = 2**PTR_W;

  logic [8*RW_COUNT-1:0] rw_q;
  logic [7:0]            reg_view [NREG];

  // RW byte storage; an address outside the RW range matches no byte and writes nothing
  always_ff @(posedge clk) begin
    if (rst) begin
      rw_q <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < RW_COUNT; i++) begin
        if (wr_addr == i[PTR_W-1:0]) begin
          rw_q[8*i +: 8] <= wr_data;
        end
      end
    end
  end

  // Full register map seen by the reader: RW bytes first, then the application's RO bytes
  for (genvar g = 0; g < NREG; g++) begin : g_view
    if (g < RW_COUNT) begin : g_rw
      assign reg_view[g] = rw_q[8*g +: 8];
    end else begin : g_ro
      assign reg_view[g] = ro_in[8*(g-RW_COUNT) +: 8];
    end
  end

  assign rd_data  = reg_view[rd_addr];
  assign regs_out = rw_q;

endmodule

// File: rtl/i2c_register_file.sv
// Pointer-protocol register file behind an I2C slave: first write byte sets ptr, later bytes auto-increment.
// Latency: writes and reg_wr_stb one edge after rx strobe; i2c_data_tx follows ptr/register changes by one edge.
// Backpressure: none; the slave's byte timing is far slower than the 2-cycle read path, so no stall exists.
module i2c_register_file
  import i2c_register_file_pkg::*;
#(
  parameter  int PTR_W    = 4,
  parameter  int RW_COUNT = 8,
  // When every register is RW there are no RO bytes; ro_in keeps one unused byte so the port stays legal
  localparam int RO_COUNT = (2**PTR_W) - RW_COUNT,
  localparam int RO_W     = (RO_COUNT > 0) ? 8*RO_COUNT : 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            i2c_addr_rw,
  input  logic                  i2c_addr_rw_valid_stb,
  input  logic [7:0]            i2c_data_rx,
  input  logic                  i2c_data_rx_valid_stb,
  output logic [7:0]            i2c_data_tx,
  input  logic                  i2c_data_tx_loaded_stb,
  input  logic                  i2c_error_stb,
  input  logic [RO_W-1:0]       ro_in,
  output logic [8*RW_COUNT-1:0] regs_out,
  output logic                  reg_wr_stb,
  output logic [PTR_W-1:0]      reg_wr_addr
);

  // RW_COUNT as a PTR_W+1 bit value so the range test compares like widths
  localparam logic [PTR_W:0] RW_LIMIT = RW_COUNT[PTR_W:0];

  state_t           state_q;
  state_t           state_d;
  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;
  logic             wr_req;
  logic             ptr_in_rw;
  logic [7:0]       rd_data;
  logic             addr_unused;

  // Only the R/W# bit matters; the slave already filtered on its own address
  assign addr_unused = ^i2c_addr_rw[7:1];

  assign ptr_in_rw = ({1'b0, ptr_q} < RW_LIMIT);

  // State and pointer registers; pointer survives errors and transfer boundaries
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next state, pointer and write request; error beats address strobe beats data strobes
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    wr_req  = 1'b0;
    if (i2c_error_stb) begin
      state_d = ST_IDLE;
    end else if (i2c_addr_rw_valid_stb) begin
      state_d = i2c_addr_rw[RW_BIT] ? ST_READ : ST_PTR;
    end else begin
      unique case (state_q)
        ST_PTR: begin
          if (i2c_data_rx_valid_stb) begin
            ptr_d   = i2c_data_rx[PTR_W-1:0];
            state_d = ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (i2c_data_rx_valid_stb) begin
            // Bytes aimed at RO registers are dropped but still advance the pointer
            wr_req = ptr_in_rw;
            ptr_d  = ptr_q + 1'b1;
          end
        end
        ST_READ: begin
          if (i2c_data_tx_loaded_stb) begin
            ptr_d = ptr_q + 1'b1;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  // Registered outputs: tx byte refreshed every cycle, write strobe one cycle after the rx byte
  always_ff @(posedge clk) begin
    if (rst) begin
      i2c_data_tx <= 8'h00;
      reg_wr_stb  <= 1'b0;
      reg_wr_addr <= '0;
    end else begin
      i2c_data_tx <= rd_data;
      reg_wr_stb  <= wr_req;
      if (wr_req) begin
        reg_wr_addr <= ptr_q;
      end
    end
  end

  i2c_register_file_reg_bank #(
    .PTR_W    (PTR_W),
    .RW_COUNT (RW_COUNT),
    .RO_W     (RO_W)
  ) u_bank (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_req),
    .wr_addr  (ptr_q),
    .wr_data  (i2c_data_rx),
    .rd_addr  (ptr_q),
    .ro_in    (ro_in),
    .regs_out (regs_out),
    .rd_data  (rd_data)
  );

endmodule

// File: tb/tb_i2c_register_file.sv
// Bench for i2c_register_file: directed test-plan steps, then random strobes against a reference model.
// Inputs change and outputs are sampled on the falling edge; every cycle is compared to the model.
// No flow control to exercise; strobes are single-cycle pulses.
module tb_i2c_register_file;

  localparam int PTR_W    = 4;
  localparam int RW_COUNT = 8;
  localparam int NREG     = 2**PTR_W;
  localparam int RO_COUNT = NREG - RW_COUNT;

  localparam int M_IDLE  = 0;
  localparam int M_PTR   = 1;
  localparam int M_WRITE = 2;
  localparam int M_READ  = 3;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [7:0]            i2c_addr_rw;
  logic                  i2c_addr_rw_valid_stb;
  logic [7:0]            i2c_data_rx;
  logic                  i2c_data_rx_valid_stb;
  logic [7:0]            i2c_data_tx;
  logic                  i2c_data_tx_loaded_stb;
  logic                  i2c_error_stb;
  logic [8*RO_COUNT-1:0] ro_in;
  logic [8*RW_COUNT-1:0] regs_out;
  logic                  reg_wr_stb;
  logic [PTR_W-1:0]      reg_wr_addr;

  int checks = 0;
  int errors = 0;

  // Reference model of the register map and pointer protocol
  logic [7:0]       m_regs [RW_COUNT];
  int               m_ptr  = 0;
  int               m_mode = M_IDLE;
  logic [7:0]       exp_tx;
  logic             exp_stb;
  logic [PTR_W-1:0] exp_wr_addr;

  always #5 clk = ~clk;

  i2c_register_file #(
    .PTR_W    (PTR_W),
    .RW_COUNT (RW_COUNT)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .i2c_addr_rw            (i2c_addr_rw),
    .i2c_addr_rw_valid_stb  (i2c_addr_rw_valid_stb),
    .i2c_data_rx            (i2c_data_rx),
    .i2c_data_rx_valid_stb  (i2c_data_rx_valid_stb),
    .i2c_data_tx            (i2c_data_tx),
    .i2c_data_tx_loaded_stb (i2c_data_tx_loaded_stb),
    .i2c_error_stb          (i2c_error_stb),
    .ro_in                  (ro_in),
    .regs_out               (regs_out),
    .reg_wr_stb             (reg_wr_stb),
    .reg_wr_addr            (reg_wr_addr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at %0t: observed=%0h expected=%0h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic [7:0] m_value(input int p);
    if (p < RW_COUNT) return m_regs[p];
    return ro_in[8*(p-RW_COUNT) +: 8];
  endfunction

  function automatic logic [8*RW_COUNT-1:0] m_packed();
    logic [8*RW_COUNT-1:0] v;
    for (int k = 0; k < RW_COUNT; k++) v[8*k +: 8] = m_regs[k];
    return v;
  endfunction

  function automatic logic [7:0] reg_byte(input int k);
    return regs_out[8*k +: 8];
  endfunction

  // One clock: advance the model on the current inputs, then compare every output after the edge
  task automatic tick();
    logic [7:0] next_tx;
    next_tx = m_value(m_ptr);
    exp_stb = 1'b0;
    if (rst) begin
      for (int k = 0; k < RW_COUNT; k++) m_regs[k] = 8'h00;
      m_ptr       = 0;
      m_mode      = M_IDLE;
      next_tx     = 8'h00;
      exp_wr_addr = '0;
    end else if (i2c_error_stb) begin
      m_mode = M_IDLE;
    end else if (i2c_addr_rw_valid_stb) begin
      m_mode = i2c_addr_rw[0] ? M_READ : M_PTR;
    end else if (m_mode == M_PTR && i2c_data_rx_valid_stb) begin
      m_ptr  = int'(i2c_data_rx) % NREG;
      m_mode = M_WRITE;
    end else if (m_mode == M_WRITE && i2c_data_rx_valid_stb) begin
      if (m_ptr < RW_COUNT) begin
        m_regs[m_ptr] = i2c_data_rx;
        exp_stb       = 1'b1;
        exp_wr_addr   = m_ptr[PTR_W-1:0];
      end
      m_ptr = (m_ptr + 1) % NREG;
    end else if (m_mode == M_READ && i2c_data_tx_loaded_stb) begin
      m_ptr = (m_ptr + 1) % NREG;
    end
    exp_tx = next_tx;
    @(negedge clk);
    chk("cyc_wr_stb",  64'(reg_wr_stb),  64'(exp_stb));
    chk("cyc_wr_addr", 64'(reg_wr_addr), 64'(exp_wr_addr));
    chk("cyc_tx",      64'(i2c_data_tx), 64'(exp_tx));
    chk("cyc_regs",    64'(regs_out),    64'(m_packed()));
    rst                    = 1'b0;
    i2c_addr_rw_valid_stb  = 1'b0;
    i2c_data_rx_valid_stb  = 1'b0;
    i2c_data_tx_loaded_stb = 1'b0;
    i2c_error_stb          = 1'b0;
  endtask

  task automatic send_addr(input logic [7:0] a);
    i2c_addr_rw = a;
    i2c_addr_rw_valid_stb = 1'b1;
    tick();
  endtask

  task automatic send_rx(input logic [7:0] d);
    i2c_data_rx = d;
    i2c_data_rx_valid_stb = 1'b1;
    tick();
  endtask

  task automatic send_loaded();
    i2c_data_tx_loaded_stb = 1'b1;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst                    = 1'b1;
    i2c_addr_rw            = 8'h00;
    i2c_addr_rw_valid_stb  = 1'b0;
    i2c_data_rx            = 8'h00;
    i2c_data_rx_valid_stb  = 1'b0;
    i2c_data_tx_loaded_stb = 1'b0;
    i2c_error_stb          = 1'b0;
    ro_in                  = 64'h5CE6D5C4B3A29180;

    // Reset state
    tick();
    chk("rst_regs", 64'(regs_out),    64'h0);
    chk("rst_tx",   64'(i2c_data_tx), 64'h00);
    chk("rst_stb",  64'(reg_wr_stb),  64'h0);
    chk("rst_addr", 64'(reg_wr_addr), 64'h0);
    idle(2);

    // Basic write: ptr 2, then 0xAA, 0xBB
    send_addr(8'h84);
    send_rx(8'h02);
    send_rx(8'hAA);
    chk("basic_stb0",  64'(reg_wr_stb),  64'h1);
    chk("basic_addr0", 64'(reg_wr_addr), 64'h2);
    send_rx(8'hBB);
    chk("basic_stb1",  64'(reg_wr_stb),  64'h1);
    chk("basic_addr1", 64'(reg_wr_addr), 64'h3);
    chk("basic_reg2",  64'(reg_byte(2)), 64'hAA);
    chk("basic_reg3",  64'(reg_byte(3)), 64'hBB);
    idle(1);
    chk("basic_stb_end", 64'(reg_wr_stb), 64'h0);

    // Read back from ptr 2 with auto-increment on tx_loaded
    send_addr(8'h84);
    send_rx(8'h02);
    send_addr(8'h85);
    idle(2);
    chk("rd_first", 64'(i2c_data_tx), 64'hAA);
    send_loaded();
    idle(1);
    chk("rd_next", 64'(i2c_data_tx), 64'hBB);

    // RO region and pointer wrap
    send_addr(8'h84);
    send_rx(8'h0F);
    send_rx(8'h11);
    chk("ro_no_stb", 64'(reg_wr_stb), 64'h0);
    send_rx(8'h22);
    chk("wrap_stb",  64'(reg_wr_stb),  64'h1);
    chk("wrap_addr", 64'(reg_wr_addr), 64'h0);
    chk("wrap_reg0", 64'(reg_byte(0)), 64'h22);
    send_addr(8'h84);
    send_rx(8'h0F);
    send_addr(8'h85);
    idle(2);
    chk("ro_read15", 64'(i2c_data_tx), 64'h5C);
    send_loaded();
    idle(1);
    chk("ro_wrap_read0", 64'(i2c_data_tx), 64'h22);

    // Error abort: ptr 5 kept, later byte discarded
    send_addr(8'h84);
    send_rx(8'h05);
    send_rx(8'h3C);
    send_addr(8'h84);
    send_rx(8'h05);
    i2c_error_stb = 1'b1;
    tick();
    send_rx(8'h99);
    chk("err_no_stb", 64'(reg_wr_stb),  64'h0);
    chk("err_reg5",   64'(reg_byte(5)), 64'h3C);
    send_addr(8'h85);
    idle(2);
    chk("err_ptr5", 64'(i2c_data_tx), 64'h3C);

    // Repeated START: write ptr 3 then read without STOP
    send_addr(8'h84);
    send_rx(8'h03);
    send_addr(8'h85);
    idle(2);
    chk("rstart_tx", 64'(i2c_data_tx), 64'hBB);

    // Address strobe and error in the same cycle: error wins, later bytes ignored
    i2c_addr_rw = 8'h84;
    i2c_addr_rw_valid_stb = 1'b1;
    i2c_error_stb = 1'b1;
    tick();
    send_rx(8'h09);
    send_rx(8'h66);
    chk("prio_no_stb", 64'(reg_wr_stb), 64'h0);
    send_addr(8'h85);
    idle(2);
    chk("prio_ptr_kept", 64'(i2c_data_tx), 64'hBB);

    // Reset in the middle of a write transfer
    send_addr(8'h84);
    send_rx(8'h01);
    send_rx(8'h77);
    chk("mid_reg1", 64'(reg_byte(1)), 64'h77);
    rst = 1'b1;
    tick();
    chk("mid_rst_regs", 64'(regs_out),    64'h0);
    chk("mid_rst_tx",   64'(i2c_data_tx), 64'h00);
    chk("mid_rst_stb",  64'(reg_wr_stb),  64'h0);
    send_rx(8'h55);
    chk("mid_idle_ignore", 64'(reg_wr_stb), 64'h0);
    send_addr(8'h85);
    for (int i = 0; i < 8; i++) send_loaded();
    idle(1);
    chk("mid_rst_ptr0", 64'(i2c_data_tx), 64'h80);

    // Random strobes against the model
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 99) < 3) ro_in = {$urandom, $urandom};
      i2c_addr_rw            = 8'($urandom);
      i2c_data_rx            = 8'($urandom);
      i2c_addr_rw_valid_stb  = ($urandom_range(0, 99) < 8);
      i2c_data_rx_valid_stb  = ($urandom_range(0, 99) < 35);
      i2c_data_tx_loaded_stb = ($urandom_range(0, 99) < 25);
      i2c_error_stb          = ($urandom_range(0, 99) < 3);
      rst                    = ($urandom_range(0, 199) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
